// File: rtl/char_text_renderer_if.sv
// Memory-side bus of the text renderer: text RAM read port and glyph ROM read port.
// master = renderer, slave = text RAM + character ROM.
interface char_text_renderer_if #(
  parameter int TADDR_W = 13
);
  logic [TADDR_W-1:0] text_addr;
  logic               text_en;
  logic [6:0]         text_char;
  logic [6:0]         char_addr;
  logic [2:0]         row_addr;
  logic [7:0]         rom_dout;

  modport master (
    output text_addr, text_en, char_addr, row_addr,
    input  text_char, rom_dout
  );

  modport slave (
    input  text_addr, text_en, char_addr, row_addr,
    output text_char, rom_dout
  );
endinterface

// File: rtl/char_text_renderer.sv
// 8x8 text-mode renderer: VGA timing in, text RAM / glyph ROM lookup, one pixel per clk, 4-clk latency.
// Optional blinking block cursor when CHAR_CURSOR_EN is defined.
module char_text_renderer #(
  parameter int H_CHARS = 80,
  parameter int V_CHARS = 60,
  parameter int TADDR_W = 13
`ifdef CHAR_CURSOR_EN
  , parameter int BLINK_FRAMES = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic       disp_en,
  input  logic       hsync_in,
  input  logic       vsync_in,
`ifdef CHAR_CURSOR_EN
  input  logic       cursor_on,
  input  logic [6:0] cursor_col,
  input  logic [5:0] cursor_row,
`endif
  char_text_renderer_if.master mem,
  output logic       pixel_out,
  output logic       de_out,
  output logic       hsync_out,
  output logic       vsync_out
);

  typedef struct packed {
    logic [2:0] px;
    logic       de;
    logic       rng;
    logic       hs;
    logic       vs;
`ifdef CHAR_CURSOR_EN
    logic       cur;
`endif
  } stage_t;

  stage_t             s0, s1, s2, s3;
  logic [2:0]         row1;
  logic [TADDR_W-1:0] text_addr_q;
  logic               text_en_q;
  logic [2:0]         row_addr_q;
  logic               in_range;
  logic [TADDR_W-1:0] addr_next;
  logic               pix_next;

  assign in_range  = (int'(h_count[9:3]) < H_CHARS) && (int'(v_count[9:3]) < V_CHARS);
  // Out-of-range cells alias to arbitrary addresses; text_en masks them.
  assign addr_next = TADDR_W'(v_count[9:3]) * TADDR_W'(H_CHARS) + TADDR_W'(h_count[9:3]);

  always_comb begin
    s0.px  = h_count[2:0];
    s0.de  = disp_en;
    s0.rng = in_range;
    s0.hs  = hsync_in;
    s0.vs  = vsync_in;
`ifdef CHAR_CURSOR_EN
    s0.cur = cursor_on && (h_count[9:3] == cursor_col) && (v_count[9:3] == {1'b0, cursor_row});
`endif
  end

`ifdef CHAR_CURSOR_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;
  logic             vs_prev;

  // Down-counts vsync rising edges; terminal count flips the blink phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= CNT_W'(BLINK_FRAMES - 1);
      blink_phase <= 1'b0;
      vs_prev     <= 1'b0;
    end else begin
      vs_prev <= vsync_in;
      if (vsync_in && !vs_prev) begin
        if (blink_cnt == '0) begin
          blink_cnt   <= CNT_W'(BLINK_FRAMES - 1);
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt - 1'b1;
        end
      end
    end
  end
`endif

  always_comb begin
    pix_next = s3.de & s3.rng & mem.rom_dout[s3.px];
`ifdef CHAR_CURSOR_EN
    if (s3.de && s3.cur && blink_phase) pix_next = ~pix_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1          <= '0;
      s2          <= '0;
      s3          <= '0;
      row1        <= '0;
      text_addr_q <= '0;
      text_en_q   <= 1'b0;
      row_addr_q  <= '0;
      pixel_out   <= 1'b0;
      de_out      <= 1'b0;
      hsync_out   <= 1'b0;
      vsync_out   <= 1'b0;
    end else begin
      s1          <= s0;
      s2          <= s1;
      s3          <= s2;
      row1        <= v_count[2:0];
      text_addr_q <= addr_next;
      text_en_q   <= disp_en & in_range;
      row_addr_q  <= row1;
      pixel_out   <= pix_next;
      de_out      <= s3.de;
      hsync_out   <= s3.hs;
      vsync_out   <= s3.vs;
    end
  end

  assign mem.text_addr = text_addr_q;
  assign mem.text_en   = text_en_q;
  assign mem.row_addr  = row_addr_q;
  // The ROM registers its address, so the character code passes straight through.
  assign mem.char_addr = mem.text_char;

endmodule
